// File: rtl/nco_channel_scheduler_pkg.sv
// Shared types and default widths for the NCO channel scheduler.
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int NCO_NUM_CH  = 4;
  localparam int NCO_PHASE_W = 16;
  localparam int NCO_ADDR_W  = 8;
  localparam int NCO_DATA_W  = 16;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nco_channel_scheduler_if.sv
// Host configuration write channel plus the tagged sample output stream.
interface nco_channel_scheduler_if
  import nco_pkg::*;
#(
  parameter int NUM_CH  = NCO_NUM_CH,
  parameter int PHASE_W = NCO_PHASE_W,
  parameter int DATA_W  = NCO_DATA_W
) ();
  localparam int CH_W = ch_w(NUM_CH);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [PHASE_W-1:0] cfg_ftw;
  logic               cfg_en;
  logic               cfg_phase_clr;

  logic               sample_valid;
  logic [CH_W-1:0]    sample_ch;
  logic [DATA_W-1:0]  sample_data;

  modport master (
    output cfg_valid, cfg_ch, cfg_ftw, cfg_en, cfg_phase_clr,
    input  cfg_ready, sample_valid, sample_ch, sample_data
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_ftw, cfg_en, cfg_phase_clr,
    output cfg_ready, sample_valid, sample_ch, sample_data
  );
endinterface

// File: rtl/nco_channel_scheduler_phase_bank.sv
// Per-channel tuning word, enable and phase accumulator storage.
module nco_phase_bank
  import nco_pkg::*;
#(
  parameter int NUM_CH  = NCO_NUM_CH,
  parameter int PHASE_W = NCO_PHASE_W,
  parameter int ADDR_W  = NCO_ADDR_W,
  parameter int CH_W    = ch_w(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [PHASE_W-1:0] wr_ftw,
  input  logic               wr_en,
  input  logic               wr_clr,
  input  logic               adv,
  input  logic [CH_W-1:0]    adv_ch,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [NUM_CH-1:0]  en_mask,
  output logic [ADDR_W-1:0]  rd_addr
);

  logic [PHASE_W-1:0] ftw   [NUM_CH];
  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [NUM_CH-1:0]  en;

  // Writes only happen in IDLE and advances only in ADDR, so they never collide;
  // an out-of-range wr_ch matches no entry and is silently dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ftw[i]   <= '0;
        phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && int'(wr_ch) == i) begin
          ftw[i] <= wr_ftw;
          en[i]  <= wr_en;
          if (wr_clr) phase[i] <= '0;
        end else if (adv && int'(adv_ch) == i) begin
          phase[i] <= phase[i] + ftw[i];
        end
      end
    end
  end

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rd_ch) == i) rd_addr = phase[i][PHASE_W-1 -: ADDR_W];
    end
  end

  assign en_mask = en;

endmodule

// File: rtl/nco_channel_scheduler.sv
// Sweeps enabled NCO channels through one shared synchronous sine ROM per tick.
module nco_channel_scheduler
  import nco_pkg::*;
#(
  parameter int NUM_CH  = NCO_NUM_CH,
  parameter int PHASE_W = NCO_PHASE_W,
  parameter int ADDR_W  = NCO_ADDR_W,
  parameter int DATA_W  = NCO_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    ovr_clr,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    busy,
  output logic                    overrun,
  nco_channel_scheduler_if.slave  bus
);

  localparam int CH_W = ch_w(NUM_CH);

  state_t            state, state_d;
  logic [CH_W-1:0]   cur_ch, cur_d;
  logic [NUM_CH-1:0] en_mask, en_snap;
  logic [ADDR_W-1:0] rd_addr;
  logic [CH_W:0]     search;
  logic              cfg_wr;
  logic              vld_p1;
  logic [CH_W-1:0]   ch_p1;
  logic [DATA_W-1:0] data_p1;

  // Lowest enabled index >= from, returned as {found, index}.
  function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] mask, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && i >= from) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  assign bus.cfg_ready = (state == IDLE) && !tick;
  assign cfg_wr        = bus.cfg_valid && bus.cfg_ready;

  nco_phase_bank #(
    .NUM_CH (NUM_CH),
    .PHASE_W(PHASE_W),
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr     (cfg_wr),
    .wr_ch  (bus.cfg_ch),
    .wr_ftw (bus.cfg_ftw),
    .wr_en  (bus.cfg_en),
    .wr_clr (bus.cfg_phase_clr),
    .adv    (state == ADDR),
    .adv_ch (cur_ch),
    .rd_ch  (cur_d),
    .en_mask(en_mask),
    .rd_addr(rd_addr)
  );

  always_comb begin
    state_d = state;
    cur_d   = cur_ch;
    search  = '0;
    case (state)
      IDLE: begin
        search = find_next(en_mask, 0);
        if (tick && search[CH_W]) begin
          state_d = ADDR;
          cur_d   = search[CH_W-1:0];
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        search = find_next(en_snap, int'(cur_ch) + 1);
        if (search[CH_W]) begin
          state_d = ADDR;
          cur_d   = search[CH_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur_ch  <= '0;
      en_snap <= '0;
    end else begin
      state  <= state_d;
      cur_ch <= cur_d;
      if (state == IDLE && tick) en_snap <= en_mask;
    end
  end

  // Stage p1: ROM address is loaded on entry to ADDR so the synchronous ROM
  // answers during DATA; the captured word appears one cycle after DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      ch_p1    <= '0;
      data_p1  <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (state_d == ADDR) rom_addr <= rd_addr;
      vld_p1 <= (state == DATA);
      if (state == DATA) begin
        ch_p1   <= cur_ch;
        data_p1 <= rom_data;
      end
      busy <= (state_d != IDLE);
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)          overrun <= 1'b0;
    end
  end

  assign bus.sample_valid = vld_p1;
  assign bus.sample_ch    = ch_p1;
  assign bus.sample_data  = data_p1;

endmodule

// File: tb/tb_nco_channel_scheduler.sv
// Directed bench for nco_channel_scheduler with a {8'hA5, addr} synchronous ROM model.
module tb_nco_channel_scheduler;
  import nco_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              ovr_clr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              overrun;

  int total = 0;
  int bad   = 0;

  nco_channel_scheduler_if #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .DATA_W(DATA_W)) bus ();

  nco_channel_scheduler #(
    .NUM_CH (NUM_CH),
    .PHASE_W(PHASE_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .ovr_clr (ovr_clr),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy    (busy),
    .overrun (overrun),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= {8'hA5, rom_addr};

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] ftw, input logic en, input logic clr);
    bus.cfg_valid     = 1'b1;
    bus.cfg_ch        = ch;
    bus.cfg_ftw       = ftw;
    bus.cfg_en        = en;
    bus.cfg_phase_clr = clr;
    chk("cfg_ready_idle", bus.cfg_ready, 1);
    step();
    bus.cfg_valid     = 1'b0;
    bus.cfg_phase_clr = 1'b0;
  endtask

  // One tick; sample j must appear in cycle 3+2j with the given channel/data.
  task automatic sweep(input int k, input logic [7:0] chs, input logic [63:0] dat, input string tag);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk({tag, "_busy_c1"}, busy, 1);
    step();
    for (int j = 0; j < k; j++) begin
      step();
      chk({tag, "_valid"}, bus.sample_valid, 1);
      chk({tag, "_ch"}, bus.sample_ch, chs[2*j +: 2]);
      chk({tag, "_data"}, bus.sample_data, dat[16*j +: 16]);
      if (j < k - 1) begin
        step();
        chk({tag, "_gap"}, bus.sample_valid, 0);
        chk({tag, "_busy_mid"}, busy, 1);
      end
    end
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [15:0] d;
    int cnt;
    int n;
    logic seen_v;
    logic seen_b;

    rst = 1'b0;
    tick = 1'b0;
    ovr_clr = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_ftw = '0;
    bus.cfg_en = 1'b0;
    bus.cfg_phase_clr = 1'b0;
    step();
    step();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_ch", bus.sample_ch, 0);
    chk("rst_data", bus.sample_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    rst = 1'b1;
    step();

    // single channel, addresses 0,1,2,3
    cfg_write(2'd0, 16'h0100, 1'b1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      d = 16'hA500 + 16'(t);
      sweep(1, 8'h00, {48'h0, d}, "single");
      repeat (5) step();
    end

    // ch0 + ch2, ch1/ch3 skipped
    cfg_write(2'd0, 16'h0100, 1'b1, 1'b1);
    cfg_write(2'd2, 16'h8000, 1'b1, 1'b1);
    sweep(2, 8'h08, {32'h0, 16'hA500, 16'hA500}, "multi0");
    repeat (3) step();
    sweep(2, 8'h08, {32'h0, 16'hA580, 16'hA501}, "multi1");
    repeat (3) step();
    sweep(2, 8'h08, {32'h0, 16'hA500, 16'hA502}, "multi2");
    repeat (3) step();

    // wrap: phases 0000, FFFF, FFFE, FFFD -> top bytes 00, FF, FF, FF
    cfg_write(2'd0, 16'h0100, 1'b0, 1'b0);
    cfg_write(2'd2, 16'h8000, 1'b0, 1'b0);
    cfg_write(2'd1, 16'hFFFF, 1'b1, 1'b1);
    sweep(1, 8'h01, {48'h0, 16'hA500}, "wrap0");
    sweep(1, 8'h01, {48'h0, 16'hA5FF}, "wrap1");
    sweep(1, 8'h01, {48'h0, 16'hA5FF}, "wrap2");
    sweep(1, 8'h01, {48'h0, 16'hA5FF}, "wrap3");
    repeat (2) step();

    // overrun: second tick in cycle 3 is dropped
    cfg_write(2'd0, 16'h0100, 1'b1, 1'b1);
    cfg_write(2'd1, 16'h0200, 1'b1, 1'b1);
    cfg_write(2'd2, 16'h0300, 1'b1, 1'b1);
    cfg_write(2'd3, 16'h0400, 1'b1, 1'b1);
    cnt = 0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    cnt += int'(bus.sample_valid);
    step();
    cnt += int'(bus.sample_valid);
    step();
    cnt += int'(bus.sample_valid);
    tick = 1'b1;
    step();
    tick = 1'b0;
    cnt += int'(bus.sample_valid);
    chk("ovr_set", overrun, 1);
    repeat (12) begin
      step();
      cnt += int'(bus.sample_valid);
    end
    chk("ovr_sample_count", cnt, 4);
    chk("ovr_busy_after", busy, 0);
    chk("ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // tick and cfg_valid together: tick wins, write lands on first IDLE cycle
    tick = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 2'd0;
    bus.cfg_ftw = 16'h0100;
    bus.cfg_en = 1'b1;
    bus.cfg_phase_clr = 1'b1;
    #1;
    chk("coll_cfg_ready", bus.cfg_ready, 0);
    step();
    tick = 1'b0;
    chk("coll_busy", busy, 1);
    n = 0;
    while (!bus.cfg_ready && n < 20) begin
      step();
      n++;
    end
    chk("coll_wait_cycles", n, 8);
    step();
    bus.cfg_valid = 1'b0;
    bus.cfg_phase_clr = 1'b0;
    sweep(4, 8'hE4, {16'hA508, 16'hA506, 16'hA504, 16'hA500}, "coll");
    repeat (2) step();

    // reset asserted during DATA of ch1 (cycle 4)
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    step();
    chk("mid_busy_pre", busy, 1);
    chk("mid_addr_pre", rom_addr, 8'h06);
    rst = 1'b0;
    #1;
    chk("mid_rom_addr", rom_addr, 0);
    chk("mid_valid", bus.sample_valid, 0);
    chk("mid_ch", bus.sample_ch, 0);
    chk("mid_data", bus.sample_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_overrun", overrun, 0);
    step();
    step();
    rst = 1'b1;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    seen_v = 1'b0;
    seen_b = 1'b0;
    repeat (8) begin
      seen_v |= bus.sample_valid;
      seen_b |= busy;
      step();
    end
    chk("post_rst_no_sample", seen_v, 0);
    chk("post_rst_no_busy", seen_b, 0);
    chk("post_rst_cfg_ready", bus.cfg_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
